// File: rtl/uart_byte_tx.sv
// Serial byte transmitter: 4-deep input FIFO feeding a start/data/stop framer paced by bit_tick strobes.
// Define UART_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_byte_tx #(
    parameter int DATA_W  = 8,
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bit_tick,
    input  logic [DATA_W-1:0]  din,
    input  logic               din_valid,
    output logic               din_ready,
    output logic               txd,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = $clog2(DATA_W);
    localparam logic [FIFO_AW:0] FULL     = (FIFO_AW + 1)'(DEPTH);
    localparam logic [CW-1:0]    LAST_BIT = CW'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_count;

    state_t             r_state;
    logic [DATA_W-1:0]  r_sh;
    logic [CW-1:0]      r_bit_cnt;
    logic               r_txd;
    logic               r_tick_q;
`ifdef UART_PARITY_EN
    logic               r_par;
`endif

    logic               w_strobe;
    logic               w_push;
    logic               w_pop;
    logic               w_empty;
    logic [DATA_W-1:0]  w_head;

    assign w_strobe = bit_tick & ~r_tick_q;
    assign w_empty  = (r_count == '0);
    assign w_head   = r_mem[r_rd_ptr];
    // Ready comes from the registered count, so a full FIFO refuses a push even while popping.
    assign w_push   = din_valid & din_ready;
    assign w_pop    = w_strobe & ~w_empty & ((r_state == S_IDLE) | (r_state == S_STOP));

    assign din_ready  = (r_count != FULL);
    assign fifo_count = r_count;
    assign txd        = r_txd;
    assign busy       = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sh      <= '0;
            r_bit_cnt <= '0;
            r_txd     <= 1'b1;
            r_tick_q  <= 1'b1;
`ifdef UART_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_tick_q <= bit_tick;
            if (w_strobe) begin
                case (r_state)
                    S_IDLE, S_STOP: begin
                        // Stop with data waiting goes straight into the next start bit.
                        if (!w_empty) begin
                            r_sh    <= w_head;
                            r_txd   <= 1'b0;
                            r_state <= S_START;
`ifdef UART_PARITY_EN
                            r_par   <= ^w_head;
`endif
                        end else begin
                            r_txd   <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    S_START: begin
                        r_txd     <= r_sh[0];
                        r_bit_cnt <= '0;
                        r_state   <= S_DATA;
                    end
                    S_DATA: begin
                        if (r_bit_cnt != LAST_BIT) begin
                            r_sh      <= r_sh >> 1;
                            r_txd     <= r_sh[1];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else begin
`ifdef UART_PARITY_EN
                            r_txd   <= r_par;
                            r_state <= S_PARITY;
`else
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end
                    end
`ifdef UART_PARITY_EN
                    S_PARITY: begin
                        r_txd   <= 1'b1;
                        r_state <= S_STOP;
                    end
`endif
                    default: begin
                        r_txd   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Randomized scoreboard bench for uart_byte_tx: a line decoder checks each frame against the byte queue.
module tb_uart_byte_tx;

`ifdef UART_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int P = 27;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_tick = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;

    uart_byte_tx #(.DATA_W(8), .FIFO_AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_tick   (bit_tick),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Divider model: fixed 27-cycle period, can be held low.
    bit tick_en = 1'b1;
    int tc = 0;
    always @(posedge clk) begin
        #2;
        tc = (tc == P - 1) ? 0 : tc + 1;
        bit_tick = tick_en && (tc < 13);
    end

    // Reference model state
    logic [7:0] exp_q[$];
    int         starts[$];
    int         cnt_m = 0;
    int         peak = 0;
    bit         busy_m = 1'b0;
    int         left = 0;
    bit         pend_hs = 1'b0;
    logic [7:0] pend_din = 8'h00;
    bit         pend_bt = 1'b0;
    bit         pend_rst = 1'b1;
    bit         tq = 1'b1;
    bit         prev_txd = 1'b1;
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [FRAME-1:0] bits;
    int         frames = 0;
    int         last_fell = 0;

    task automatic check_frame(input logic [FRAME-1:0] b);
        logic [7:0] d;
        d = b[8:1];
        chk("start_bit", b[0], 1'b0);
        chk("stop_bit", b[FRAME-1], 1'b1);
`ifdef UART_PARITY_EN
        chk("parity_bit", b[9], ^d);
`endif
        if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_frame: got %02h expected no frame", d);
        end else begin
            chk("frame_data", d, exp_q.pop_front());
        end
    endtask

    always @(negedge clk) begin
        bit stb;
        bit fell;
        bit boundary;
        int cnt_before;
        if (rst) begin
            chk("rst_txd", txd, 1);
            chk("rst_busy", busy, 0);
            chk("rst_count", fifo_count, 0);
            chk("rst_ready", din_ready, 1);
            exp_q.delete();
            cnt_m = 0; busy_m = 0; left = 0; pend_hs = 0; tq = 1;
            pend_rst = 1; pend_bt = bit_tick; mon_act = 0; prev_txd = 1;
        end else begin
            stb = !pend_rst && pend_bt && !tq;
            tq = pend_rst ? 1'b1 : pend_bt;
            cnt_before = cnt_m;
            if (pend_hs) begin
                cnt_m++;
                exp_q.push_back(pend_din);
            end
            if (txd !== prev_txd) chk("txd_on_strobe", stb, 1);
            boundary = stb && (!busy_m || left == 1);
            fell = prev_txd && !txd && (!busy_m || left == 1);
            if (boundary || fell) chk("start_when_due", fell, boundary && (cnt_before > 0));
            if (fell) begin
                if (cnt_m > 0) cnt_m--;
                busy_m = 1; left = FRAME; frames++;
                starts.push_back(cyc); last_fell = cyc;
                mon_act = 1; mon_cnt = 0;
            end else if (stb && busy_m) begin
                left--;
                if (left == 0) busy_m = 0;
            end
            if (cnt_m > peak) peak = cnt_m;
            chk("fifo_count", fifo_count, cnt_m);
            chk("din_ready", din_ready, cnt_m != 4);
            chk("busy", busy, busy_m);
            if (mon_act && !fell) begin
                mon_cnt++;
                if (mon_cnt % P == 13) begin
                    bits[mon_cnt / P] = txd;
                    if (mon_cnt / P == FRAME - 1) begin
                        mon_act = 0;
                        check_frame(bits);
                    end
                end
            end
            pend_hs = din_valid && din_ready;
            pend_din = din;
            pend_bt = bit_tick;
            pend_rst = 0;
            prev_txd = txd;
        end
    end

    task automatic push(input logic [7:0] b, output int acc);
        int t;
        bit ok;
        t = 0; ok = 0; acc = 0;
        @(posedge clk); #1;
        din = b; din_valid = 1;
        while (!ok) begin
            @(negedge clk);
            ok = din_ready;
            @(posedge clk); #1;
            t++;
            if (!ok && t > 5000) begin
                n_chk++; n_fail++;
                $display("FAIL push_timeout: got no handshake expected one within 5000 cycles");
                ok = 1;
            end
        end
        acc = cyc;
        din_valid = 0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!(cnt_m == 0 && !busy_m && !pend_hs && !mon_act) && t < 20000);
        if (t >= 20000) begin
            n_chk++; n_fail++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", t);
        end
    endtask

    initial begin
        int acc;
        int s0;
        int t;
        int fb;
        logic [7:0] b;

        // 1: reset with divider running, then nothing starts on an empty FIFO
        repeat (40) @(posedge clk);
        #1 rst = 0;
        repeat (300) @(posedge clk);
        #1;
        chk("t1_no_frame", frames, 0);
        chk("t1_txd_idle", txd, 1);

        // 2: single byte
        push(8'hA5, acc);
        wait_idle();
        chk("t2_frames", frames, 1);

        // 3: back-to-back frames
        peak = 0;
        s0 = starts.size();
        push(8'h00, acc);
        t = 0;
        while (!busy_m && t < 200) begin @(negedge clk); t++; end
        push(8'hFF, acc);
        push(8'h55, acc);
        wait_idle();
        chk("t3_peak", peak, 2);
        chk("t3_frames", starts.size() - s0, 3);
        if (starts.size() - s0 == 3) begin
            chk("t3_gap1", starts[s0+1] - starts[s0], FRAME * P);
            chk("t3_gap2", starts[s0+2] - starts[s0+1], FRAME * P);
        end

        // 4: divider stalled, FIFO fills, fifth byte waits for the first pop
        @(posedge clk); #1 tick_en = 0;
        repeat (30) @(posedge clk);
        for (int i = 0; i < 4; i++) push(8'($urandom), acc);
        repeat (3) @(negedge clk);
        chk("t4_count_full", fifo_count, 4);
        chk("t4_ready_low", din_ready, 0);
        chk("t4_no_frame", busy, 0);
        tick_en = 1;
        push(8'h3C, acc);
        chk("t4_fifth_after_pop", acc, last_fell + 1);
        wait_idle();

        // 5: reset during data bit 3
        push(8'hC3, acc);
        push(8'h96, acc);
        t = 0;
        while (!(mon_act && mon_cnt == 4 * P + 5) && t < 2000) begin @(negedge clk); t++; end
        chk("t5_reached_bit3", mon_cnt, 4 * P + 5);
        @(posedge clk); #1 rst = 1;
        #1;
        chk("t5_txd_high", txd, 1);
        chk("t5_count_flush", fifo_count, 0);
        chk("t5_busy_low", busy, 0);
        fb = frames;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        repeat (FRAME * P * 3) @(posedge clk);
        chk("t5_no_frame", frames, fb);

        // 6: parity-sensitive byte
        push(8'h07, acc);
        wait_idle();

        // 7: random bytes with random spacing
        fb = frames;
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 60)) @(posedge clk);
            b = 8'($urandom);
            push(b, acc);
        end
        wait_idle();
        chk("t7_frames", frames - fb, 20);
        chk("t7_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global_timeout: got no finish expected finish before 5 ms");
        $fatal(1, "timeout");
    end

endmodule
